mdu_hilo: RTL
=============

# mdu_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, holds busy while a multi-cycle operation runs, and drives `hi`/`lo`. Those two outputs are inputs to the 32-bit 8:1 writeback result mux, which returns them for MFHI/MFLO. The controller stalls the PC on `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. Only 32 is verified.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `start`  in  1  issue strobe, sampled at the rising edge.
- `op`  in  3  operation code. Encodings are defined in the shared package.
- `rs_val`  in  32  multiplicand / dividend / MTHI and MTLO source.
- `rt_val`  in  32  multiplier / divisor.
- `busy`  out  1  a multi-cycle operation is in progress. Registered.
- `done`  out  1  one-cycle pulse when HI/LO receive a multiply or divide result.
- `hi`  out  32  HI register, to the result mux.
- `lo`  out  32  LO register, to the result mux.

## Operation
- States are IDLE, RUN and FIX.
- **IDLE, accepting an operation.** When `start` is high and `busy` is low, `op` is decoded:
  - MTHI: `hi <= rs_val` in one cycle. No busy, no done.
  - MTLO: `lo <= rs_val` in one cycle. No busy, no done.
  - MULT, MULTU, DIV, DIVU: latch the operands, convert signed ops to magnitudes, record the result signs, clear the count, go to RUN.
  - Undefined `op`: ignored.
- **RUN.** One radix-2 step per cycle for 32 cycles.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
  - The count goes 0..31. Go to FIX after count 31.
- **FIX.** Apply the sign correction and write `hi`/`lo`, pulse `done`, return to IDLE.
- Multiply results:
  - `{hi,lo}` is the full 64-bit product.
  - MULT is two's-complement signed, MULTU is unsigned.
- Divide results:
  - `lo` is the quotient, `hi` the remainder.
  - Signed division truncates toward zero. The remainder takes the sign of the dividend.
- Divide-by-zero: DIV and DIVU give `lo = 0xFFFFFFFF`, `hi = rs_val`, with normal latency.
- Signed overflow: `0x80000000 / 0xFFFFFFFF` gives `lo = 0x80000000`, `hi = 0`.
- `start` while `busy` is high is ignored. No queuing.
- `hi`/`lo` hold their old values during RUN and change only in FIX.

## Timing
- Call the accept edge E0.
- E1–E32 are the RUN iterations. `busy` is high from after E0 until E33.
- At E33 (FIX) `hi`/`lo` update and `busy` falls.
- `done` is high for the single cycle after E33.
- Result latency is 33 cycles from accept, identical for every multiply and divide, including divide-by-zero.
- A new `start` can be accepted at E33+1.
- MTHI/MTLO: the new value is visible after the accept edge. `busy` stays low.
- Reset values, taking effect immediately on `rst_n` low:
  - `hi = 0`, `lo = 0`, `busy = 0`, `done = 0`.
  - State IDLE, count 0.
- Reset during RUN or FIX aborts the operation. No partial result reaches `hi`/`lo`.

## Configuration
- `MDU_DIV_EN` defined: DIV and DIVU are implemented as described.
- `MDU_DIV_EN` undefined:
  - Divide datapath is removed.
  - DIV and DIVU are treated as undefined ops. They are ignored, with no busy, no done, and `hi`/`lo` unchanged.
  - Multiply and MTHI/MTLO are unaffected.

## Structure
- Package `mdu_pkg` contains:
  - `op` encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - State enum.
  - `MDU_ITER = 32`.
- Sub-module `mdu_step`: combinational single-iteration core.
  - Inputs: 64-bit working register, 32-bit operand, mode.
  - Output: the next working register.
- The top level holds the FSM, counter, sign fixup and HI/LO.

## Test plan
- MULTU `0xFFFFFFFF × 0xFFFFFFFF` -> after 33 cycles `hi = 0xFFFFFFFE`, `lo = 0x00000001`, one `done` pulse.
- MULT `0xFFFFFFFD × 0x00000005` (−3×5) -> `hi = 0xFFFFFFFF`, `lo = 0xFFFFFFF1`.
- DIV `0xFFFFFFF9 / 0x00000002` (−7/2) -> `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`. Also DIVU `0x1234 / 0` -> `lo = 0xFFFFFFFF`, `hi = 0x1234`.
- MULTU `7 × 6` accepted, then `start` with MTLO `0xAA` at cycle 5 -> MTLO ignored; final `lo = 42`, `hi = 0`.
- MTHI `0xDEADBEEF` -> `hi = 0xDEADBEEF` next cycle, `busy` never asserted.
- DIVU in progress, `rst_n` low at cycle 10 -> `busy`, `done`, `hi`, `lo` all 0 immediately. A new MULTU after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_hilo shared definitions: op encodings, FSM states, iteration count.
// Divide support is built only when MDU_DIV_EN is defined.
package mdu_pkg;

  localparam int MDU_ITER = 32;
  localparam int CNT_W    = $clog2(MDU_ITER);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step.
// The divide path exists only when MDU_DIV_EN is defined.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2*W-1:0] work_i,
  input  logic [W-1:0]   opnd_i,
  input  mode_e          mode_i,
  output logic [2*W-1:0] work_o
);

  logic [W:0]     sum;
  logic [2*W-1:0] mul_nxt;

  // upper half accumulates, lower half holds remaining multiplier bits
  always_comb begin
    sum     = {1'b0, work_i[2*W-1:W]}
            + (work_i[0] ? {1'b0, opnd_i} : '0);
    mul_nxt = {sum, work_i[W-1:1]};
  end

`ifdef MDU_DIV_EN
  logic [W:0]     rem;
  logic [W:0]     dif;
  logic           ge;
  logic [2*W-1:0] div_nxt;

  // upper half is the partial remainder, lower half dividend/quotient
  always_comb begin
    rem     = work_i[2*W-1:W-1];
    ge      = (rem >= {1'b0, opnd_i});
    dif     = rem - {1'b0, opnd_i};
    div_nxt = {(ge ? dif[W-1:0] : rem[W-1:0]),
               work_i[W-2:0], ge};
  end

  assign work_o = (mode_i == MODE_DIV) ? div_nxt : mul_nxt;
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign work_o      = mul_nxt;
`endif

endmodule

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers, 33-cycle latency.
// Define MDU_DIV_EN to build DIV/DIVU; otherwise they are ignored.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W = WIDTH;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   work_q, work_d;
  logic [2*W-1:0]   step_w, res_w;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     rs_mag, rt_mag;
  logic [W-1:0]     rem_w, quo_w;
  mode_e            mode_q, mode_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sgn_op;

  mdu_step #(.W(W)) u_step (
    .work_i (work_q),
    .opnd_i (opnd_q),
    .mode_i (mode_q),
    .work_o (step_w)
  );

  always_comb begin
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    rs_mag = (sgn_op && rs_val[W-1]) ? -rs_val : rs_val;
    rt_mag = (sgn_op && rt_val[W-1]) ? -rt_val : rt_val;
    res_w  = neg_lo_q ? -work_q : work_q;
    rem_w  = neg_hi_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];
    quo_w  = neg_lo_q ? -work_q[W-1:0] : work_q[W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    mode_d   = mode_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          unique case (op)
            OP_MTHI: hi_d = rs_val;
            OP_MTLO: lo_d = rs_val;
            OP_MULT, OP_MULTU: begin
              work_d   = {{W{1'b0}}, rt_mag};
              opnd_d   = rs_mag;
              mode_d   = MODE_MUL;
              neg_lo_d = sgn_op && (rs_val[W-1] ^ rt_val[W-1]);
              neg_hi_d = 1'b0;
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = S_RUN;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              work_d   = {{W{1'b0}}, rs_mag};
              opnd_d   = rt_mag;
              mode_d   = MODE_DIV;
              // zero divisor: all-ones quotient stays unnegated
              neg_lo_d = sgn_op && (rs_val[W-1] ^ rt_val[W-1])
                       && (rt_val != '0);
              neg_hi_d = sgn_op && rs_val[W-1];
              cnt_d    = '0;
              busy_d   = 1'b1;
              state_d  = S_RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        work_d = step_w;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MDU_ITER - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (mode_q == MODE_DIV) begin
          hi_d = rem_w;
          lo_d = quo_w;
        end else begin
          hi_d = res_w[2*W-1:W];
          lo_d = res_w[W-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      mode_q   <= MODE_MUL;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      mode_q   <= mode_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
